branch_history_table: RTL and testbench

//   Parametrised 2-bit saturating-counter branch history table for the lc3b fetch stage.
//   - Fetch presents a PC and gets a combinational taken/not-taken prediction, plus the table index used.
//   - The resolving stage returns that index and the actual outcome; the counter is updated one clock later.
//   - After reset, an init sweep writes every entry. Same-cycle update->predict forwarding is built in.

---
 rtl/branch_history_table_if.sv | 20 ++
 rtl/branch_history_table.sv | 68 ++++++
 tb/tb_branch_history_table.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_history_table_if.sv
// branch_history_table_if: fetch-side prediction and resolve-side update bundle for the branch history table
interface branch_history_table_if #(
  parameter int INDEX_BITS = 3
);
  logic [15:0]           pred_pc;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  branch_predict;
  logic                  pred_ready;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic                  upd_taken;
  modport master (
    output pred_pc, upd_valid, upd_index, upd_taken,
    input  pred_index, branch_predict, pred_ready
  );
  modport slave (
    input  pred_pc, upd_valid, upd_index, upd_taken,
    output pred_index, branch_predict, pred_ready
  );
endinterface

// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit saturating-counter BHT with init sweep and update forwarding; BHT_GSHARE_EN adds gshare indexing
module branch_history_table #(
  parameter int         INDEX_BITS = 3,
  parameter int         PC_LSB     = 1,
  parameter int         HIST_BITS  = 3,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_history_table_if.slave bus
);
  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0]            r_state;
  logic [INDEX_BITS-1:0] r_init_ptr;
  logic [1:0]            r_table [DEPTH];
  logic                  w_run;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_cur;
  logic [1:0]            w_next;
  logic                  w_fwd;
  if (INDEX_BITS < 1 || HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_cfg
    $error("branch_history_table: need INDEX_BITS >= 1 and 1 <= HIST_BITS <= INDEX_BITS");
  end
  // a reset in flight also blanks the outputs and blocks updates
  assign w_run = rst_n && (r_state == S_RUN);
`ifdef BHT_GSHARE_EN
  logic [HIST_BITS-1:0] r_ghr;
  assign w_index = bus.pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(r_ghr);
  if (HIST_BITS == 1) begin : g_h1
    // single-bit history just remembers the last resolved outcome
    always_ff @(posedge clk)
      if (!rst_n) r_ghr <= '0;
      else if (w_run && bus.upd_valid) r_ghr <= bus.upd_taken;
  end else begin : g_hn
    // non-speculative history shifts in each accepted resolved outcome
    always_ff @(posedge clk)
      if (!rst_n) r_ghr <= '0;
      else if (w_run && bus.upd_valid) r_ghr <= {r_ghr[HIST_BITS-2:0], bus.upd_taken};
  end
`else
  assign w_index = bus.pred_pc[PC_LSB +: INDEX_BITS];
`endif
  // INIT sweeps the table once, then RUN holds until the next reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_ptr <= '0;
    end else if (r_state == S_INIT) begin
      r_init_ptr <= r_init_ptr + INDEX_BITS'(1);
      if (r_init_ptr == '1) r_state <= S_RUN;
    end
  // saturating next value for the counter being resolved; also drives forwarding
  always_comb begin
    w_cur  = r_table[bus.upd_index];
    w_next = bus.upd_taken ? ((w_cur == 2'b11) ? w_cur : w_cur + 2'd1)
                           : ((w_cur == 2'b00) ? w_cur : w_cur - 2'd1);
    w_fwd  = bus.upd_valid && (bus.upd_index == w_index);
  end
  // single write port: the sweep owns it in INIT, resolved updates in RUN
  always_ff @(posedge clk)
    if (rst_n && r_state == S_INIT) r_table[r_init_ptr] <= INIT_STATE;
    else if (w_run && bus.upd_valid) r_table[bus.upd_index] <= w_next;
  assign bus.pred_index     = w_index;
  assign bus.pred_ready     = w_run;
  assign bus.branch_predict = w_run && (w_fwd ? w_next[1] : r_table[w_index][1]);
endmodule

// File: tb/tb_branch_history_table.sv
// tb_branch_history_table: scoreboard bench for branch_history_table (INDEX_BITS=3, HIST_BITS=2)
module tb_branch_history_table;
`ifdef BHT_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif
  logic clk;
  logic rst_n;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] sb[$];
  logic [7:0] e;
  logic [1:0] m_ghr = 2'b00;
  branch_history_table_if #(.INDEX_BITS(3)) bus();
  branch_history_table #(.INDEX_BITS(3), .PC_LSB(1), .HIST_BITS(2), .INIT_STATE(2'b01)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] pc_of(input logic [2:0] idx);
    logic [2:0] b;
    b = idx ^ {1'b0, m_ghr};
    return 16'h3000 | {12'b0, b, 1'b0};
  endfunction
  task automatic upd(input logic [2:0] idx, input logic t);
    bus.upd_valid = 1'b1;
    bus.upd_index = idx;
    bus.upd_taken = t;
    tick();
    bus.upd_valid = 1'b0;
    if (GS) m_ghr = {m_ghr[0], t};
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_index = 3'd0;
    bus.upd_taken = 1'b0;
    bus.pred_pc = 16'h3004;
    tick();
    tick();
    sb.push_back(8'd0); sb.push_back(8'd0); sb.push_back(8'd2);
    e = sb.pop_front(); n_tests++;
    if (bus.pred_ready !== e[0]) begin n_fail++; $display("FAIL reset_ready got %b want %b", bus.pred_ready, e[0]); end
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL reset_predict got %b want %b", bus.branch_predict, e[0]); end
    e = sb.pop_front(); n_tests++;
    if (bus.pred_index !== e[2:0]) begin n_fail++; $display("FAIL reset_index got %0d want %0d", bus.pred_index, e[2:0]); end
  endtask
  task automatic test_init();
    bus.upd_valid = 1'b1;
    bus.upd_index = 3'd2;
    bus.upd_taken = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'd0);
      e = sb.pop_front(); n_tests++;
      if (bus.pred_ready !== e[0]) begin n_fail++; $display("FAIL init_ready_cycle%0d got %b want %b", i, bus.pred_ready, e[0]); end
      tick();
    end
    bus.upd_valid = 1'b0;
    sb.push_back(8'd1);
    e = sb.pop_front(); n_tests++;
    if (bus.pred_ready !== e[0]) begin n_fail++; $display("FAIL init_ready_done got %b want %b", bus.pred_ready, e[0]); end
    for (int i = 0; i < 8; i++) begin
      bus.pred_pc = pc_of(3'(i));
      #1;
      sb.push_back(8'd0);
      e = sb.pop_front(); n_tests++;
      if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL init_entry%0d got %b want %b", i, bus.branch_predict, e[0]); end
    end
  endtask
  task automatic test_train_up();
    logic tk [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic ex [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      upd(3'd2, tk[i]);
      sb.push_back({7'b0, ex[i]});
      bus.pred_pc = pc_of(3'd2);
      #1;
      e = sb.pop_front(); n_tests++;
      if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL train_up_step%0d got %b want %b", i, bus.branch_predict, e[0]); end
    end
  endtask
  task automatic test_saturate_low();
    logic tk [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic ex [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      upd(3'd5, tk[i]);
      sb.push_back({7'b0, ex[i]});
      bus.pred_pc = pc_of(3'd5);
      #1;
      e = sb.pop_front(); n_tests++;
      if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL sat_low_step%0d got %b want %b", i, bus.branch_predict, e[0]); end
    end
  endtask
  task automatic test_forwarding();
    bus.pred_pc = pc_of(3'd3);
    bus.upd_valid = 1'b1; bus.upd_index = 3'd3; bus.upd_taken = 1'b1;
    sb.push_back(8'd1);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL fwd_same_cycle got %b want %b", bus.branch_predict, e[0]); end
    tick();
    bus.upd_valid = 1'b0;
    if (GS) m_ghr = {m_ghr[0], 1'b1};
    bus.pred_pc = pc_of(3'd3);
    sb.push_back(8'd1);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL fwd_next_cycle got %b want %b", bus.branch_predict, e[0]); end
    bus.pred_pc = pc_of(3'd4);
    bus.upd_valid = 1'b1; bus.upd_index = 3'd6; bus.upd_taken = 1'b1;
    sb.push_back(8'd0);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL fwd_other_index got %b want %b", bus.branch_predict, e[0]); end
    tick();
    bus.upd_valid = 1'b0;
    if (GS) m_ghr = {m_ghr[0], 1'b1};
    bus.pred_pc = pc_of(3'd6);
    sb.push_back(8'd1);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL upd_idx6 got %b want %b", bus.branch_predict, e[0]); end
    bus.pred_pc = pc_of(3'd2);
    bus.upd_valid = 1'b1; bus.upd_index = 3'd2; bus.upd_taken = 1'b0;
    sb.push_back(8'd0);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL fwd_not_taken got %b want %b", bus.branch_predict, e[0]); end
    tick();
    bus.upd_valid = 1'b0;
    if (GS) m_ghr = {m_ghr[0], 1'b0};
  endtask
  task automatic test_mid_reset();
    upd(3'd2, 1'b1);
    upd(3'd2, 1'b1);
    bus.pred_pc = pc_of(3'd2);
    sb.push_back(8'd1);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL mid_pretrain got %b want %b", bus.branch_predict, e[0]); end
    rst_n = 1'b0;
    #1;
    sb.push_back(8'd0);
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL mid_rst_predict got %b want %b", bus.branch_predict, e[0]); end
    tick();
    m_ghr = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.upd_valid = 1'b1; bus.upd_index = 3'd0; bus.upd_taken = 1'b1;
      sb.push_back(8'd0);
      e = sb.pop_front(); n_tests++;
      if (bus.pred_ready !== e[0]) begin n_fail++; $display("FAIL mid_sweep_cycle%0d got %b want %b", i, bus.pred_ready, e[0]); end
      tick();
    end
    bus.upd_valid = 1'b0;
    sb.push_back(8'd1);
    e = sb.pop_front(); n_tests++;
    if (bus.pred_ready !== e[0]) begin n_fail++; $display("FAIL mid_ready_done got %b want %b", bus.pred_ready, e[0]); end
    bus.pred_pc = pc_of(3'd2);
    sb.push_back(8'd0);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.branch_predict !== e[0]) begin n_fail++; $display("FAIL mid_idx2_cleared got %b want %b", bus.branch_predict, e[0]); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(8'd0);
      e = sb.pop_front(); n_tests++;
      if (bus.pred_ready !== e[0]) begin n_fail++; $display("FAIL resweep_cycle%0d got %b want %b", i, bus.pred_ready, e[0]); end
      tick();
    end
    sb.push_back(8'd1);
    e = sb.pop_front(); n_tests++;
    if (bus.pred_ready !== e[0]) begin n_fail++; $display("FAIL resweep_done got %b want %b", bus.pred_ready, e[0]); end
  endtask
  task automatic test_gshare();
    bus.pred_pc = 16'h0002;
    sb.push_back(8'd1);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.pred_index !== e[2:0]) begin n_fail++; $display("FAIL gshare_idx_ghr0 got %0d want %0d", bus.pred_index, e[2:0]); end
    upd(3'd0, 1'b1);
    upd(3'd0, 1'b1);
    bus.pred_pc = 16'h0002;
    sb.push_back(GS ? 8'd2 : 8'd1);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.pred_index !== e[2:0]) begin n_fail++; $display("FAIL gshare_idx_ghr3 got %0d want %0d", bus.pred_index, e[2:0]); end
    bus.pred_pc = 16'hFFFE;
    sb.push_back(GS ? 8'd4 : 8'd7);
    #1;
    e = sb.pop_front(); n_tests++;
    if (bus.pred_index !== e[2:0]) begin n_fail++; $display("FAIL gshare_idx_top got %0d want %0d", bus.pred_index, e[2:0]); end
  endtask
  initial begin
    test_reset();
    test_init();
    test_train_up();
    test_saturate_low();
    test_forwarding();
    test_mid_reset();
    test_gshare();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
